// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V funct3
// encodings and the access-size data mask.
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 8192;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StErr
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Right-aligned bit mask covering an access of 1 << size bytes.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] mask;
    case (size)
      2'd0:    mask = 64'h0000_0000_0000_00ff;
      2'd1:    mask = 64'h0000_0000_0000_ffff;
      2'd2:    mask = 64'h0000_0000_ffff_ffff;
      default: mask = 64'hffff_ffff_ffff_ffff;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory port of the load/store unit.
// The slave modport is the unit itself; master is its environment.
interface lsu_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_load;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_writeData;
  logic            mem_MemWrite;
  logic            mem_MemRead;
  logic [XLEN-1:0] mem_readData;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, mem_readData,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_address, mem_writeData, mem_MemWrite, mem_MemRead
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, mem_readData,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_address, mem_writeData, mem_MemWrite, mem_MemRead
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a memory doubleword and a sized access: extended
// load value and read-modify-write merged store doubleword.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [5:0]  shamt;
  logic [63:0] mask;
  logic [63:0] shifted;
  logic [63:0] raw;
  logic        sign;

  always_comb begin
    shamt   = {offset, 3'b000};
    mask    = size_mask(funct3[1:0]);
    shifted = rdata >> shamt;
    raw     = shifted & mask;
    case (funct3[1:0])
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[63];
    endcase
    // funct3[2] selects the unsigned (zero-extending) load variants.
    load_data  = (!funct3[2] && sign) ? (raw | ~mask) : raw;
    store_data = (rdata & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns sized pipeline requests into doubleword
// accesses on a one-cycle-latency memory, with read-modify-write for narrow stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned XLEN      = 64
) (
  input logic clk,
  input logic reset,
  lsu_if.slave bus
);

  lsu_state_e      state_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            is_load_q;
  logic [XLEN-1:0] merge_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_err_q;

  logic            misaligned;
  logic            req_err;
  logic [63:0]     load_data;
  logic [63:0]     store_data;

  always_comb begin
    case (bus.req_funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase
    req_err = misaligned
           || (bus.req_addr >= XLEN'(MEM_BYTES))
           || (bus.req_load == bus.req_store)
           || (bus.req_load && (bus.req_funct3 == 3'b111))
           || (bus.req_store && bus.req_funct3[2]);
  end

  lsu_lane_align u_lane_align (
    .rdata      (bus.mem_readData),
    .offset     (addr_q[2:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      is_load_q    <= 1'b0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q    <= bus.req_addr;
            wdata_q   <= bus.req_wdata;
            funct3_q  <= bus.req_funct3;
            is_load_q <= bus.req_load;
            if (req_err) begin
              state_q <= StErr;
            end else if (bus.req_store && (bus.req_funct3[1:0] == F3_D[1:0])) begin
              // Full doubleword store needs no read-back.
              merge_q <= bus.req_wdata;
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: state_q <= StCap;
        StCap: begin
          if (is_load_q) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_data;
            state_q      <= StIdle;
          end else begin
            merge_q <= store_data;
            state_q <= StWr;
          end
        end
        StWr: begin
          resp_valid_q <= 1'b1;
          state_q      <= StIdle;
        end
        StErr: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready     = (state_q == StIdle);
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.mem_MemRead   = (state_q == StRd);
  assign bus.mem_MemWrite  = (state_q == StWr);
  assign bus.mem_address   = ((state_q == StRd) || (state_q == StWr)) ?
                             {addr_q[XLEN-1:3], 3'b000} : '0;
  assign bus.mem_writeData = (state_q == StWr) ? merge_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of sized requests against a
// behavioural one-cycle-latency memory, plus reset-abort and reset-state sequences.
module tb_load_store_unit;

  logic clk;
  logic reset;
  logic mem_clr;

  lsu_if #(.XLEN(64)) bus ();

  load_store_unit #(.MEM_BYTES(8192), .XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data memory: 1024 doublewords, synchronous read, invalid -> 0.
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      bus.mem_readData <= '0;
    end else begin
      if (bus.mem_MemWrite && (bus.mem_address < 64'd8192))
        mem[bus.mem_address[12:3]] <= bus.mem_writeData;
      bus.mem_readData <= (bus.mem_MemRead && (bus.mem_address < 64'd8192)) ?
                          mem[bus.mem_address[12:3]] : 64'd0;
    end
  end

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  always @(negedge clk) begin
    if (bus.mem_MemRead) rd_cnt++;
    if (bus.mem_MemWrite) begin
      wr_cnt++;
      last_wr_addr = bus.mem_address;
      last_wr_data = bus.mem_writeData;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [63:0] exp_wr;
  } vec_t;

  function automatic vec_t mk(input string name, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] exp_data,
                              input logic exp_err, input int exp_lat,
                              input logic [63:0] exp_wr);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_wr = exp_wr;
    return v;
  endfunction

  // Entered just after a negedge with the unit idle; returns just after the
  // negedge on which resp_valid was seen, so the next call is back-to-back.
  task automatic run_req(input vec_t v);
    int          lat;
    int          low;
    int          rd0;
    int          wr0;
    int          exp_rd;
    int          exp_wr;
    logic [63:0] d;
    logic        e;
    check({v.name, " ready_before"}, {63'd0, bus.req_ready}, 64'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_load   = v.ld;
    bus.req_store  = v.st;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    lat = 0;
    low = 0;
    d   = '1;
    e   = 1'bx;
    for (int k = 1; (k <= 10) && (lat == 0); k++) begin
      @(negedge clk);
      if (!bus.req_ready) low++;
      if (bus.resp_valid) begin
        lat = k;
        d   = bus.resp_data;
        e   = bus.resp_err;
      end
    end
    #1;
    exp_rd = (!v.exp_err && (v.ld || (v.f3[1:0] != 2'b11))) ? 1 : 0;
    exp_wr = (!v.exp_err && v.st) ? 1 : 0;
    check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({v.name, " resp_data"}, d, v.exp_data);
    check({v.name, " resp_err"}, {63'd0, e}, {63'd0, v.exp_err});
    check({v.name, " ready_low_cycles"}, 64'(low), 64'(v.exp_lat - 1));
    check({v.name, " read_strobes"}, 64'(rd_cnt - rd0), 64'(exp_rd));
    check({v.name, " write_strobes"}, 64'(wr_cnt - wr0), 64'(exp_wr));
    if (exp_wr == 1) begin
      check({v.name, " wr_address"}, last_wr_addr, {v.addr[63:3], 3'b000});
      check({v.name, " wr_data"}, last_wr_data, v.exp_wr);
    end
  endtask

  vec_t vecs[$];
  int   wr_base;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    reset   = 1'b0;
    mem_clr = 1'b1;

    vecs.push_back(mk("SD_100",   0, 1, 3'b011, 64'h100, 64'h8877665544332211, 64'h0, 0, 2,
                      64'h8877665544332211));
    vecs.push_back(mk("LB_103",   1, 0, 3'b000, 64'h103, 64'h0, 64'h44, 0, 3, 64'h0));
    vecs.push_back(mk("LB_107",   1, 0, 3'b000, 64'h107, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, 3,
                      64'h0));
    vecs.push_back(mk("LBU_107",  1, 0, 3'b100, 64'h107, 64'h0, 64'h88, 0, 3, 64'h0));
    vecs.push_back(mk("LH_106",   1, 0, 3'b001, 64'h106, 64'h0, 64'hFFFFFFFFFFFF8877, 0, 3,
                      64'h0));
    vecs.push_back(mk("LHU_106",  1, 0, 3'b101, 64'h106, 64'h0, 64'h8877, 0, 3, 64'h0));
    vecs.push_back(mk("LW_104",   1, 0, 3'b010, 64'h104, 64'h0, 64'hFFFFFFFF88776655, 0, 3,
                      64'h0));
    vecs.push_back(mk("LWU_104",  1, 0, 3'b110, 64'h104, 64'h0, 64'h0000000088776655, 0, 3,
                      64'h0));
    vecs.push_back(mk("SH_102",   0, 1, 3'b001, 64'h102, 64'h12345678BBBB, 64'h0, 0, 4,
                      64'h88776655BBBB2211));
    vecs.push_back(mk("LD_100",   1, 0, 3'b011, 64'h100, 64'h0, 64'h88776655BBBB2211, 0, 3,
                      64'h0));
    vecs.push_back(mk("SB_208",   0, 1, 3'b000, 64'h208, 64'h12AB, 64'h0, 0, 4,
                      64'h00000000000000AB));
    vecs.push_back(mk("SW_20C",   0, 1, 3'b010, 64'h20C, 64'h1111DEADBEEF, 64'h0, 0, 4,
                      64'hDEADBEEF000000AB));
    vecs.push_back(mk("LB_208",   1, 0, 3'b000, 64'h208, 64'h0, 64'hFFFFFFFFFFFFFFAB, 0, 3,
                      64'h0));
    vecs.push_back(mk("LD_208",   1, 0, 3'b011, 64'h208, 64'h0, 64'hDEADBEEF000000AB, 0, 3,
                      64'h0));
    vecs.push_back(mk("LD_1FF8",  1, 0, 3'b011, 64'h1FF8, 64'h0, 64'h0, 0, 3, 64'h0));
    vecs.push_back(mk("LBU_1FFF", 1, 0, 3'b100, 64'h1FFF, 64'h0, 64'h0, 0, 3, 64'h0));
    vecs.push_back(mk("LW_102_mis", 1, 0, 3'b010, 64'h102, 64'h0, 64'h0, 1, 2, 64'h0));
    vecs.push_back(mk("LD_2000_oor", 1, 0, 3'b011, 64'h2000, 64'h0, 64'h0, 1, 2, 64'h0));
    vecs.push_back(mk("LB_2000_oor", 1, 0, 3'b000, 64'h2000, 64'h0, 64'h0, 1, 2, 64'h0));
    vecs.push_back(mk("SD_104_mis", 0, 1, 3'b011, 64'h104, 64'h5, 64'h0, 1, 2, 64'h0));
    vecs.push_back(mk("L_f3_111", 1, 0, 3'b111, 64'h100, 64'h0, 64'h0, 1, 2, 64'h0));
    vecs.push_back(mk("S_f3_100", 0, 1, 3'b100, 64'h100, 64'h77, 64'h0, 1, 2, 64'h0));
    vecs.push_back(mk("LD_and_ST", 1, 1, 3'b000, 64'h100, 64'h77, 64'h0, 1, 2, 64'h0));
    vecs.push_back(mk("neither",  0, 0, 3'b000, 64'h100, 64'h77, 64'h0, 1, 2, 64'h0));

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst mem_MemRead", {63'd0, bus.mem_MemRead}, 64'd0);
    check("rst mem_MemWrite", {63'd0, bus.mem_MemWrite}, 64'd0);
    check("rst resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    reset   = 1'b1;
    mem_clr = 1'b0;
    @(negedge clk);
    check("rel req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rel resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rel resp_data", bus.resp_data, 64'd0);
    check("rel resp_err", {63'd0, bus.resp_err}, 64'd0);
    check("rel mem_address", bus.mem_address, 64'd0);
    check("rel mem_writeData", bus.mem_writeData, 64'd0);
    check("rel mem_MemWrite", {63'd0, bus.mem_MemWrite}, 64'd0);
    #1;

    // Table runs back-to-back: each request is driven in its predecessor's resp cycle.
    foreach (vecs[i]) run_req(vecs[i]);

    // SH 0x100 aborted by reset during CAP: the write must never happen.
    bus.req_valid  = 1'b1;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 64'h100;
    bus.req_wdata  = 64'hCCCC;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    @(negedge clk);
    check("abort RD mem_MemRead", {63'd0, bus.mem_MemRead}, 64'd1);
    @(negedge clk);
    check("abort CAP req_ready", {63'd0, bus.req_ready}, 64'd0);
    wr_base = wr_cnt;
    reset = 1'b0;
    @(negedge clk);
    check("abort post-edge mem_MemWrite", {63'd0, bus.mem_MemWrite}, 64'd0);
    check("abort post-edge req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("abort post-edge resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("abort no later writes", 64'(wr_cnt - wr_base), 64'd0);
    check("abort idle req_ready", {63'd0, bus.req_ready}, 64'd1);
    run_req(mk("LD_100_after_abort", 1, 0, 3'b011, 64'h100, 64'h0, 64'h88776655BBBB2211, 0,
               3, 64'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
